mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter.sv | 91 +++++++++
 tb/tb_mod_counter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Bounded up/down counter with wrap or saturate at MAX_VAL, terminal-count pulse and sticky overflow.
// Define MOD_COUNTER_PRESCALE_EN to step only on every PRESCALE-th enabled cycle.
module mod_counter #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 200,
    parameter int          PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] data,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    function automatic logic is_boundary(input logic [WIDTH-1:0] cur, input logic up);
        return up ? (cur >= MAX_V) : (cur == '0);
    endfunction

    // Next count for one step; at a boundary either hold (saturate) or jump to the far bound.
    function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] cur,
                                                  input logic up,
                                                  input logic sat_mode);
        if (up) begin
            if (cur >= MAX_V) return sat_mode ? MAX_V : '0;
            return cur + 1'b1;
        end
        if (cur == '0) return sat_mode ? '0 : MAX_V;
        return cur - 1'b1;
    endfunction

    logic step;
    logic bnd;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] presc;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            presc <= '0;
        end else if (enable) begin
            presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
        end
    end

    assign step = enable && (presc == PS_LAST);
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE > 0);
    assign step            = enable;
`endif

    assign bnd = is_boundary(data, up_dn);

    // Count register stage: load wins over a step in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                data <= clamp_max(load_val);
            end else if (step) begin
                data <= step_val(data, up_dn, sat);
                tc   <= bnd;
            end
            if (!load && step && bnd) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter (WIDTH=4, MAX_VAL=9); expectations queued as stimulus is driven.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset, enable, up_dn, sat, load, clr_ovf;
    logic [3:0] load_val;
    logic [3:0] data;
    logic       tc, ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [3:0] d;
        logic       tc;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .up_dn   (up_dn),
        .sat     (sat),
        .load    (load),
        .load_val(load_val),
        .clr_ovf (clr_ovf),
        .data    (data),
        .tc      (tc),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected registered result, then compare after the edge.
    task automatic cyc(input string tag, input logic r, input logic en, input logic ud,
                       input logic s, input logic ld, input logic [3:0] lv, input logic clr,
                       input logic [3:0] ed, input logic etc, input logic eovf);
        exp_t e;
        reset = r; enable = en; up_dn = ud; sat = s; load = ld; load_val = lv; clr_ovf = clr;
        e.tag = tag; e.d = ed; e.tc = etc; e.ovf = eovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".data"}, 32'(data), 32'(e.d));
        chk({e.tag, ".tc"},   32'(tc),   32'(e.tc));
        chk({e.tag, ".ovf"},  32'(ovf),  32'(e.ovf));
    endtask

    initial begin
        logic [3:0] ed;
        reset = 1'b0; enable = 1'b0; up_dn = 1'b1; sat = 1'b0;
        load = 1'b0; load_val = '0; clr_ovf = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) cyc("reset", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

`ifdef MOD_COUNTER_PRESCALE_EN
        for (int i = 1; i <= 12; i++) begin
            ed = 4'(i / 4);
            cyc("pre_up", 0, 1, 1, 0, 0, 0, 0, ed, 0, 0);
        end
        cyc("pre_en1", 0, 1, 1, 0, 0, 0, 0, 3, 0, 0);
        cyc("pre_en2", 0, 1, 1, 0, 0, 0, 0, 3, 0, 0);
        cyc("pre_hold1", 0, 0, 1, 0, 0, 0, 0, 3, 0, 0);
        cyc("pre_hold2", 0, 0, 1, 0, 0, 0, 0, 3, 0, 0);
        cyc("pre_en3", 0, 1, 1, 0, 0, 0, 0, 3, 0, 0);
        cyc("pre_step", 0, 1, 1, 0, 0, 0, 0, 4, 0, 0);
        cyc("pre_load", 0, 1, 1, 0, 1, 7, 0, 7, 0, 0);
        for (int i = 0; i < 3; i++) cyc("pre_after_load", 0, 1, 1, 0, 0, 0, 0, 7, 0, 0);
        cyc("pre_load_step", 0, 1, 1, 0, 0, 0, 0, 8, 0, 0);
`else
        for (int i = 1; i <= 12; i++) begin
            ed = 4'(i % 10);
            cyc("wrap_up", 0, 1, 1, 0, 0, 0, 0, ed, (i == 10), (i >= 10));
        end

        cyc("load8", 0, 0, 1, 1, 1, 8, 0, 8, 0, 1);
        cyc("sat_up1", 0, 1, 1, 1, 0, 0, 0, 9, 0, 1);
        cyc("sat_up2", 0, 1, 1, 1, 0, 0, 0, 9, 1, 1);
        cyc("sat_up3", 0, 1, 1, 1, 0, 0, 0, 9, 1, 1);
        cyc("clr_ovf", 0, 0, 1, 1, 0, 0, 1, 9, 0, 0);
        cyc("idle_dir", 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);

        cyc("load1", 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        cyc("dn1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("dn_wrap", 0, 1, 0, 0, 0, 0, 0, 9, 1, 1);
        cyc("dn3", 0, 1, 0, 0, 0, 0, 0, 8, 0, 1);

        cyc("load9", 0, 0, 1, 0, 1, 9, 0, 9, 0, 1);
        cyc("clr2", 0, 0, 1, 0, 0, 0, 1, 9, 0, 0);
        cyc("set_vs_clr", 0, 1, 1, 0, 0, 0, 1, 0, 1, 1);

        cyc("load_clamp", 0, 1, 1, 0, 1, 15, 0, 9, 0, 1);
        cyc("reset_over", 1, 1, 1, 0, 1, 5, 1, 0, 0, 0);

        cyc("sat_dn1", 0, 1, 0, 1, 0, 0, 0, 0, 1, 1);
        cyc("sat_dn2", 0, 1, 0, 1, 0, 0, 0, 0, 1, 1);
        cyc("up_after", 0, 1, 1, 1, 0, 0, 0, 1, 0, 1);
        cyc("reset_mid", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`endif

        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
